// File: rtl/mul_k_if.sv
// Operand/product handshake bundle for the Kyber coefficient multiplier stage.
// The slave modport is the multiplier's view. The master modport is the view of whatever drives it.
interface mul_k_if #(
  parameter int IDX_W = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [11:0]      a_i;
  logic [11:0]      b_i;
  logic             valid_o;
  logic             ready_i;
  logic [23:0]      product_o;
  logic [IDX_W-1:0] idx_o;
  logic             last_o;
  logic             err_o;

  modport slave (
    input  valid_i, a_i, b_i, ready_i,
    output ready_o, valid_o, product_o, idx_o, last_o, err_o
  );

  modport master (
    output valid_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, product_o, idx_o, last_o, err_o
  );
endinterface

// File: rtl/mul_k.sv
// Two-stage pipelined 12x12 coefficient multiplier with polynomial index framing.
// Define MUL_K_RANGE_CHECK_EN to enable the sticky operand range error (err_o).
module mul_k #(
  parameter int N_COEFF = 256,
  parameter int Q       = 3329
) (
  input logic   clk_i,
  input logic   rst_ni,
  mul_k_if.slave bus
);
  localparam int               IDX_W   = $clog2(N_COEFF);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_COEFF - 1);

  if (N_COEFF < 2 || Q < 2 || Q > 4096) begin : g_param_check
    $error("mul_k: N_COEFF must be >= 2 and Q must be in 2..4096");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [11:0]      s1_a_q, s1_a_d;
  logic [11:0]      s1_b_q, s1_b_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s2_valid_q, s2_valid_d;
  logic [23:0]      s2_product_q, s2_product_d;
  logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
  logic             s2_last_q, s2_last_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             s1_en, s2_en, in_fire;

  // S2 may advance when empty or being popped; S1 may advance when S2 makes room.
  always_comb begin
    s2_en        = !s2_valid_q || bus.ready_i;
    s1_en        = !s1_valid_q || s2_en;
    in_fire      = bus.valid_i && s1_en;

    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_idx_d     = s1_idx_q;
    s2_valid_d   = s2_valid_q;
    s2_product_d = s2_product_q;
    s2_idx_d     = s2_idx_q;
    s2_last_d    = s2_last_q;
    cnt_d        = cnt_q;

    if (s1_en) begin
      s1_valid_d = bus.valid_i;
    end
    if (in_fire) begin
      s1_a_d   = bus.a_i;
      s1_b_d   = bus.b_i;
      s1_idx_d = cnt_q;
      cnt_d    = (cnt_q == IDX_MAX) ? '0 : cnt_q + 1'b1;
    end

    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_product_d = {12'b0, s1_a_q} * {12'b0, s1_b_q};
        s2_idx_d     = s1_idx_q;
        s2_last_d    = (s1_idx_q == IDX_MAX);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_idx_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_product_q <= '0;
      s2_idx_q     <= '0;
      s2_last_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_idx_q     <= s1_idx_d;
      s2_valid_q   <= s2_valid_d;
      s2_product_q <= s2_product_d;
      s2_idx_q     <= s2_idx_d;
      s2_last_q    <= s2_last_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.ready_o   = s1_en;
  assign bus.valid_o   = s2_valid_q;
  assign bus.product_o = s2_product_q;
  assign bus.idx_o     = s2_idx_q;
  assign bus.last_o    = s2_valid_q && s2_last_q;

`ifdef MUL_K_RANGE_CHECK_EN
  localparam logic [11:0] Q_W = 12'(Q);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (in_fire && ((bus.a_i >= Q_W) || (bus.b_i >= Q_W))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
